data_mem_access: RTL
====================

DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of ACCESS-state cycles to wait for bus_ack before a timeout fault (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req  input  1  SHALL be the access request, sampled only in IDLE.
REQ-005 we  input  1  SHALL select the access type: 1 = store, 0 = load.
REQ-006 addr  input  32  SHALL be the byte address.
REQ-007 wdata  input  32  SHALL be the store data, taken from rs2.
REQ-008 LoadType  input  3  SHALL encode the load: 000 LW, 001 LBU, 010 LB, 100 LHU, 101 LH; all other codes are illegal.
REQ-009 StoreType  input  2  SHALL encode the store: 00 SW, 01 SB, 10 SH; code 11 is illegal.
REQ-010 busy  output  1  SHALL be high whenever state != IDLE.
REQ-011 done  output  1  SHALL be a one-cycle completion pulse.
REQ-012 rdata  output  32  SHALL be the formatted, extended load result.
REQ-013 fault  output  2  SHALL give the completion status: 00 ok, 01 misaligned, 10 illegal type, 11 timeout; valid while done=1.
REQ-014 bus_req, bus_we  output  1 each  SHALL be the bus request and write enable.
REQ-015 bus_addr  output  32  SHALL be {addr[31:2],2'b00}.
REQ-016 bus_wdata  output  32  SHALL carry lane-replicated store data.
REQ-017 bus_be  output  4  SHALL carry the byte enables.
REQ-018 bus_ack  input  1  and bus_rdata  input  32  SHALL be the bus completion and read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-020 In IDLE with req=1 at a clock edge, the block SHALL latch we, addr, wdata, LoadType and StoreType, and go to ACCESS when the access is legal and aligned, otherwise to DONE with the matching fault code.
REQ-021 Alignment rules: halfword accesses with addr[0]=1 SHALL be misaligned; word accesses with addr[1:0]!=0 SHALL be misaligned; byte accesses SHALL never be misaligned.
REQ-022 When both illegal and misaligned apply, the fault code SHALL be 10 (illegal type).
REQ-023 In ACCESS, bus_req SHALL be 1 and the bus outputs SHALL be driven from the latched values; the outputs SHALL be stable until ack.
REQ-024 bus_req, bus_we and bus_be SHALL be 0 outside ACCESS.
REQ-025 Byte enables: SW SHALL give bus_be=1111; SH SHALL give 0011 when addr[1]=0 and 1100 when addr[1]=1; SB SHALL give 0001<<addr[1:0]; loads SHALL give 1111.
REQ-026 Store data: SB SHALL drive bus_wdata={4{wdata[7:0]}}; SH SHALL drive {2{wdata[15:0]}}; SW SHALL drive wdata.
REQ-027 When bus_ack=1 in ACCESS at a clock edge, the block SHALL go to DONE with fault=00; for a load, rdata SHALL capture the selected lane of bus_rdata: byte addr[1:0], half addr[1]; LB/LH sign-extended; LBU/LHU zero-extended.
REQ-028 The timeout counter SHALL clear on ACCESS entry and increment each ACCESS cycle without ack; when the count reaches TIMEOUT-1 without ack, the next edge SHALL go to DONE with fault=11.
REQ-029 An ack arriving on the same edge as the timeout SHALL win, giving fault=00.
REQ-030 In DONE, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-031 Back-to-back: a req seen in the IDLE cycle after DONE SHALL be accepted, giving a minimum 3-cycle spacing.
REQ-032 Latency: bus_req SHALL assert one cycle after req is accepted, and done SHALL assert one cycle after the ack edge.
REQ-033 req SHALL be ignored in ACCESS and DONE; bus_ack SHALL be ignored outside ACCESS.
REQ-034 rdata SHALL hold its last load value across stores; on any faulted load, rdata SHALL be 0.

Reset
REQ-035 reset_n=0 SHALL immediately force state IDLE, busy=0, done=0, fault=00, rdata=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0 and the timeout counter to 0, including in the middle of an access.
REQ-036 After reset is released, the first edge SHALL be able to accept req.

Verification
REQ-037 LB at addr=0x1003 with bus_rdata=0x80FF_1234 and ack after 2 cycles -> bus_addr=0x1000, bus_be=1111, rdata=0xFFFF_FF80, fault=00, done one cycle.
REQ-038 SH at addr=0x2002 with wdata=0xDEAD_BEEF -> bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_we=1, done after ack, rdata unchanged.
REQ-039 LW at addr=0x0006 -> no bus_req, done the cycle after accept, fault=01, rdata=0.
REQ-040 LoadType=011 at addr=0x0001 -> fault=10, no bus activity.
REQ-041 Load with bus_ack held 0 and TIMEOUT=16 -> bus_req high for 16 cycles, then done with fault=11; a second case with ack on the 16th cycle -> fault=00.
REQ-042 reset_n pulsed low while in ACCESS -> bus_req=0 asynchronously, busy=0, no done pulse; a new req is accepted after release.

Source files
------------

// File: rtl/data_mem_access.sv
// Data memory access unit: accepts one load/store request at a time, checks
// the access type and alignment, runs a single-beat bus transfer with a
// bounded wait for bus_ack, and reports completion with a one-cycle done
// pulse, a fault code and the formatted load result.
module data_mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  LoadType,
  input  logic [1:0]  StoreType,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_ILLEGAL  = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } fault_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Last ACCESS cycle count before the wait is abandoned.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  fault_e      fault_q, fault_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  stype_q, stype_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  size_e       req_size;
  logic        req_illegal;
  logic        req_misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  // Decode the incoming request: access size and legality of the type code.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case statements can infer a latch.
    req_size    = SZ_WORD;
    req_illegal = 1'b0;
    if (we) begin
      case (StoreType)
        2'b00:   req_size = SZ_WORD;
        2'b01:   req_size = SZ_BYTE;
        2'b10:   req_size = SZ_HALF;
        default: req_illegal = 1'b1;
      endcase
    end else begin
      case (LoadType)
        3'b000:         req_size = SZ_WORD;
        3'b001, 3'b010: req_size = SZ_BYTE;
        3'b100, 3'b101: req_size = SZ_HALF;
        default:        req_illegal = 1'b1;
      endcase
    end
  end

  assign req_misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                          ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = bus_rdata[7:0];
      2'b01:   ld_byte = bus_rdata[15:8];
      2'b10:   ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ltype_q)
      3'b001:  ld_result = {24'd0, ld_byte};
      3'b010:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_result = {16'd0, ld_half};
      3'b101:  ld_result = {{16{ld_half[15]}}, ld_half};
      default: ld_result = bus_rdata;
    endcase
  end

  // Next-state logic: request acceptance, bus wait with timeout, completion.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ltype_d = ltype_q;
    stype_d = stype_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          ltype_d = LoadType;
          stype_d = StoreType;
          cnt_d   = 8'd0;
          if (req_illegal || req_misaligned) begin
            // Illegal type takes precedence over misalignment.
            fault_d = req_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
            state_d = DONE;
            if (!we) rdata_d = 32'd0;
          end else begin
            fault_d = FAULT_OK;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // An ack on the final wait cycle still completes normally.
        if (bus_ack) begin
          fault_d = FAULT_OK;
          state_d = DONE;
          if (!we_q) rdata_d = ld_result;
        end else if (cnt_q == LAST_CNT) begin
          fault_d = FAULT_TIMEOUT;
          state_d = DONE;
          if (!we_q) rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q <= IDLE;
      fault_q <= FAULT_OK;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      ltype_q <= 3'd0;
      stype_q <= 2'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ltype_q <= ltype_d;
      stype_q <= stype_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus byte enables and lane-replicated store data from the latched request.
  always_comb begin
    bus_be    = 4'b0000;
    bus_wdata = wdata_q;
    case (stype_q)
      2'b01:   bus_wdata = {4{wdata_q[7:0]}};
      2'b10:   bus_wdata = {2{wdata_q[15:0]}};
      default: bus_wdata = wdata_q;
    endcase
    if (state_q == ACCESS) begin
      if (!we_q) begin
        bus_be = 4'b1111;
      end else begin
        case (stype_q)
          2'b00:   bus_be = 4'b1111;
          2'b01:   bus_be = 4'b0001 << addr_q[1:0];
          2'b10:   bus_be = addr_q[1] ? 4'b1100 : 4'b0011;
          default: bus_be = 4'b0000;
        endcase
      end
    end
  end

  assign bus_req  = (state_q == ACCESS);
  assign bus_we   = bus_req & we_q;
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign fault    = fault_q;
  assign rdata    = rdata_q;

endmodule
